// File: rtl/decoder_2to4_strobe.sv
// decoder_2to4_strobe: registered 2-to-4 decoder with a valid/ready input
// handshake and a timed one-hot strobe output.
// An accepted code drives y one-hot for HOLD cycles. Then y is forced to zero
// for GAP cycles before the next code can be accepted.
// Optional feature macro: DEC_STROBE_STATS_EN adds the accept_cnt[7:0] output,
// an accepted-code counter that wraps 255->0.
module decoder_2to4_strobe #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] code,
  output logic [3:0] y,
  output logic       busy
`ifdef DEC_STROBE_STATS_EN
  ,
  output logic [7:0] accept_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [3:0] r_y;
  logic [3:0] w_y_nxt;
  logic       w_accept;

  // The hot bit index is 3 - code.
  function automatic logic [3:0] decode(input logic [1:0] c);
    logic [3:0] v;
    case (c)
      2'b11:   v = 4'b0001;
      2'b10:   v = 4'b0010;
      2'b01:   v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

  // State, shared hold/gap down-counter and registered strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Next-state logic. The code is captured only on the accept edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_accept    = in_valid && in_ready;
    case (r_state)
      S_IDLE: begin
        w_y_nxt = '0;
        if (w_accept) begin
          w_y_nxt     = decode(code);
          w_cnt_nxt   = HOLD_LOAD;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_y_nxt = '0;
          if (GAP == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = GAP_LOAD;
            w_state_nxt = S_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_GAP: begin
        w_y_nxt = '0;
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_y_nxt     = '0;
      end
    endcase
  end

  // Outputs come from registered state only. in_ready is also masked by rst.
  always_comb begin
    in_ready = (r_state == S_IDLE) && !rst;
    busy     = (r_state != S_IDLE);
    y        = r_y;
  end

`ifdef DEC_STROBE_STATS_EN
  logic [7:0] r_accept_cnt;

  // Count accepted codes, wrapping naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_accept_cnt <= '0;
    end else if (w_accept) begin
      r_accept_cnt <= r_accept_cnt + 8'd1;
    end
  end

  // Drive the counter output.
  always_comb begin
    accept_cnt = r_accept_cnt;
  end
`endif

endmodule

// File: tb/tb_decoder_2to4_strobe.sv
// Bench for decoder_2to4_strobe. Three instances use different HOLD/GAP values.
// A timeline model predicts the outputs from the cycle count since the last
// accept. Directed phases pin the model with literal values.
module tb_decoder_2to4_strobe;
  localparam int N = 3;
  localparam int HV[N] = '{4, 1, 3};
  localparam int GV[N] = '{1, 0, 2};
  localparam int NONE = -100000;

  logic       clk = 1'b0;
  logic       rst [N];
  logic       vld [N];
  logic [1:0] cd  [N];
  logic       rdy [N];
  logic       bsy [N];
  logic [3:0] yo  [N];
`ifdef DEC_STROBE_STATS_EN
  logic [7:0] ac  [N];
`endif

  always #5 clk = ~clk;

  decoder_2to4_strobe #(.HOLD(4), .GAP(1)) u0 (
    .clk(clk), .rst(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .code(cd[0]), .y(yo[0]), .busy(bsy[0])
`ifdef DEC_STROBE_STATS_EN
    , .accept_cnt(ac[0])
`endif
  );
  decoder_2to4_strobe #(.HOLD(1), .GAP(0)) u1 (
    .clk(clk), .rst(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .code(cd[1]), .y(yo[1]), .busy(bsy[1])
`ifdef DEC_STROBE_STATS_EN
    , .accept_cnt(ac[1])
`endif
  );
  decoder_2to4_strobe #(.HOLD(3), .GAP(2)) u2 (
    .clk(clk), .rst(rst[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .code(cd[2]), .y(yo[2]), .busy(bsy[2])
`ifdef DEC_STROBE_STATS_EN
    , .accept_cnt(ac[2])
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit live  = 1'b0;
  int last_acc [N];
  int mcode    [N];
  int macc     [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int encode(input logic [3:0] v);
    case (v)
      4'b0001: return 3;
      4'b0010: return 2;
      4'b0100: return 1;
      4'b1000: return 0;
      default: return -1;
    endcase
  endfunction

  // Timeline model. An accept at edge k makes y hot for edges k..k+H-1 and
  // busy for edges k..k+H+G-1. The next accept is legal from edge k+H+G+1.
  initial begin
    for (int i = 0; i < N; i++) begin
      last_acc[i] = NONE;
      mcode[i] = 0;
      macc[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (rst[i]) begin
          last_acc[i] = NONE;
          macc[i] = 0;
        end else if (vld[i] && ((cyc - 1) - last_acc[i] >= HV[i] + GV[i])) begin
          last_acc[i] = cyc;
          mcode[i] = int'(cd[i]);
          macc[i] = (macc[i] + 1) % 256;
        end
      end
      live = 1'b1;
    end
  end

  // Compare every instance against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        for (int i = 0; i < N; i++) begin
          int d;
          logic [3:0] ey;
          d = cyc - last_acc[i];
          ey = (d < HV[i]) ? 4'(1 << (3 - mcode[i])) : 4'b0000;
          chk($sformatf("y[%0d]", i), yo[i], ey);
          chk($sformatf("busy[%0d]", i), bsy[i], (d < HV[i] + GV[i]) ? 1 : 0);
          chk($sformatf("in_ready[%0d]", i), rdy[i], (!rst[i] && d >= HV[i] + GV[i]) ? 1 : 0);
          chk($sformatf("onehot[%0d]", i), ($countones(yo[i]) <= 1) ? 1 : 0, 1);
`ifdef DEC_STROBE_STATS_EN
          chk($sformatf("accept_cnt[%0d]", i), ac[i], macc[i]);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (!rdy[i] && n < 50) begin
      step();
      n++;
    end
    chk("ready_timeout", rdy[i], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sweep_y [4];
    logic [1:0] sweep_c [4];
    sweep_y = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    sweep_c = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      cd[i]  = 2'b00;
    end
    step();
    step();
    chk("rdy_in_rst", rdy[0], 0);
    chk("y_in_rst", yo[0], 0);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    #1;
    chk("rdy_after_rst", rdy[0], 1);

    // Single accept with HOLD=4 and GAP=1.
    vld[0] = 1'b1;
    cd[0] = 2'b10;
    step();
    chk("acc_y", yo[0], 4'b0010);
    chk("acc_busy", bsy[0], 1);
    chk("acc_rdy", rdy[0], 0);
    vld[0] = 1'b1;
    cd[0] = 2'b11;
    repeat (3) step();
    chk("hold_last_y", yo[0], 4'b0010);
    step();
    chk("gap_y", yo[0], 4'b0000);
    chk("gap_busy", bsy[0], 1);
    chk("gap_rdy", rdy[0], 0);
    vld[0] = 1'b0;
    step();
    chk("idle_busy", bsy[0], 0);
    chk("idle_rdy", rdy[0], 1);

    // Sweep all four codes and re-encode each strobe.
    for (int k = 0; k < 4; k++) begin
      wait_ready(0);
      vld[0] = 1'b1;
      cd[0] = sweep_c[k];
      step();
      vld[0] = 1'b0;
      chk("sweep_y", yo[0], sweep_y[k]);
      chk("sweep_reenc", encode(yo[0]), int'(sweep_c[k]));
    end

    // Assert reset during the second HOLD cycle.
    wait_ready(0);
    vld[0] = 1'b1;
    cd[0] = 2'b01;
    step();
    vld[0] = 1'b0;
    step();
    chk("midhold_y", yo[0], 4'b0100);
    rst[0] = 1'b1;
    vld[0] = 1'b1;
    cd[0] = 2'b00;
    step();
    chk("rst_y", yo[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_rdy", rdy[0], 0);
`ifdef DEC_STROBE_STATS_EN
    chk("rst_acc_cnt", ac[0], 0);
`endif
    rst[0] = 1'b0;
    vld[0] = 1'b0;
    step();
    chk("rst_noacc_y", yo[0], 0);
    chk("rst_noacc_busy", bsy[0], 0);
    chk("rst_noacc_rdy", rdy[0], 1);

    // With HOLD=1 and GAP=0, continuous valid accepts every second edge.
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    vld[1] = 1'b1;
    for (int j = 1; j <= 513; j++) begin
      cd[1] = 2'($urandom);
      step();
      if (j <= 6) begin
        chk("alt_y_nonzero", (yo[1] != 4'b0000) ? 1 : 0, j % 2);
        chk("alt_busy", bsy[1], j % 2);
      end
    end
`ifdef DEC_STROBE_STATS_EN
    chk("wrap_acc_cnt", ac[1], 1);
`endif
    vld[1] = 1'b0;

    // Random traffic on all instances. Valid can drop and code can change
    // while the block is busy.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        rst[i] = ($urandom_range(0, 79) == 0);
        vld[i] = ($urandom_range(0, 3) != 0);
        cd[i]  = 2'($urandom);
      end
      step();
    end
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0;
      vld[i] = 1'b0;
    end
    repeat (12) step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
